nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_if.sv | 40 ++++
 rtl/nibble_serial_adder_add4.sv | 17 +
 rtl/nibble_serial_adder.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder: FSM state encoding,
// nibble width and the nibble-count helper.
package nibble_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  localparam int NIB_W = 4;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bus for nibble_serial_adder. The ovf signal exists only
// when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and payload stable until that edge; the consumer
// may assert ready at any time and ready carries no meaning while valid is 0.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit full adder: the single arithmetic stage that the
// serial adder reuses once per nibble.
module nibble_add4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout
);

  logic [4:0] w_total;

  assign w_total = {1'b0, a4} + {1'b0, b4} + {4'b0000, cin};
  assign s4      = w_total[3:0];
  assign cout    = w_total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that pushes one nibble per cycle through nibble_add4, LSB
// nibble first. Define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed ovf flag.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_adder_if.slave     bus,
  output adder_state_t             dbg_state
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int SH_W  = (NIB > 1) ? WIDTH - NIB_W : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

  if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  adder_state_t     r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [SH_W-1:0]  r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [3:0]       w_nsum;
  logic             w_ncout;
  logic [WIDTH-1:0] w_sum_next;
  logic [SH_W-1:0]  w_sh_next;

  nibble_add4 u_add4 (
    .a4   (r_a_sh[NIB_W-1:0]),
    .b4   (r_b_sh[NIB_W-1:0]),
    .cin  (r_carry),
    .s4   (w_nsum),
    .cout (w_ncout)
  );

  // Partial sums collect in the upper bits; after the last nibble the newest
  // nibble on top plus the shift register is the complete result.
  if (NIB > 1) begin : g_multi
    assign w_sum_next = {w_nsum, r_sum_sh};
    assign w_sh_next  = w_sum_next[WIDTH-1:NIB_W];
  end else begin : g_single
    assign w_sum_next = w_nsum;
    assign w_sh_next  = '0;
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && bus.in_valid && r_in_ready) begin
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
    end else if (r_state == ADD && r_cnt == LAST_CNT) begin
      r_ovf <= r_a_msb ^ r_b_msb ^ w_sum_next[WIDTH-1] ^ w_ncout;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a_sh     <= bus.a;
            r_b_sh     <= bus.b;
            r_carry    <= bus.cin;
            r_sum_sh   <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ADD;
          end
        end
        ADD: begin
          r_sum_sh <= w_sh_next;
          r_carry  <= w_ncout;
          r_a_sh   <= r_a_sh >> NIB_W;
          r_b_sh   <= r_b_sh >> NIB_W;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_ncout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // in_ready returns together with IDLE, so nothing is accepted in DONE.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.busy      = r_busy;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector
// table, reset abort, backpressure and a randomized scoreboard run.
module tb_nibble_serial_adder;
  import nibble_adder_pkg::*;

  localparam int W = 16;
  localparam int NIBS = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  adder_state_t dbg_state;
  int           errors = 0;
  int           checks = 0;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[7];

  // {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic, signed range test for ovf.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    longint ua, ub, us, sa, sb, ss;
    logic   c, o;
    ua = longint'(a);
    ub = longint'(b);
    us = ua + ub + longint'(ci);
    c  = (us >= 65536);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    ss = sa + sb + longint'(ci);
    o  = (ss > 32767) || (ss < -32768);
    return {o, c, us[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation, waits for acceptance, then waits for out_valid.
  // lat counts edges from the accepting edge to out_valid being seen high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, output int lat);
    int n;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("accept_timeout", 32'd1, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.cin = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int           seen;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NIBS));
      check($sformatf("vec%0d_sum", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
`endif
      tick();
      check($sformatf("vec%0d_handshake_ov", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("vec%0d_handshake_rdy", i), 32'(bus.in_ready), 32'd1);
      check($sformatf("vec%0d_sum_kept", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
    end

    // Reset in the middle of ADD aborts the operation
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("abort_state_add", 32'(dbg_state), 32'(ADD));
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("abort_no_result", 32'(seen), 32'd0);

    // Backpressure: result held, new operands ignored
    bus.out_ready = 1'b0;
    run_op(16'hABCD, 16'h1357, 1'b1, lat);
    check("bp_latency", 32'(lat), 32'(NIBS));
    held_sum = bus.sum;
    held_cout = bus.cout;
    check("bp_sum", 32'(held_sum), 32'h0000BF25);
    check("bp_cout", 32'(held_cout), 32'd0);
    bus.a = 16'h0001;
    bus.b = 16'h0001;
    bus.in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.sum !== held_sum || bus.cout !== held_cout || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1 || dbg_state !== DONE)
        seen++;
      tick();
    end
    check("bp_hold_cycles_bad", 32'(seen), 32'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_ov", 32'(bus.out_valid), 32'd0);
    check("bp_release_state", 32'(dbg_state), 32'(IDLE));
    check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
    check("bp_sum_after", 32'(bus.sum), 32'(held_sum));
    bus.a = 16'h0005;
    bus.b = 16'h0007;
    bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_accept", 32'(dbg_state), 32'(ADD));
    repeat (NIBS) tick();
    check("bp_next_sum", 32'(bus.sum), 32'h0000000D);
    tick();

    // Randomized back-to-back run with scoreboard
    fork
      begin : driver
        for (int i = 0; i < 50; i++) begin
          int gap, n;
          logic rdy;
          logic [W-1:0] ra, rb;
          logic rc;
          gap = $urandom_range(0, 3);
          repeat (gap) tick();
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom_range(0, 1));
          bus.a = ra;
          bus.b = rb;
          bus.cin = rc;
          bus.in_valid = 1'b1;
          n = 0;
          do begin
            rdy = bus.in_ready;
            tick();
            n++;
          end while (!rdy && n < 200);
          if (!rdy) check("rand_accept_timeout", 32'd1, 32'd0);
          else exp_q.push_back(ref_add(ra, rb, rc));
          bus.in_valid = 1'b0;
        end
      end
      begin : monitor
        int got, cyc;
        logic [W+1:0] e;
        got = 0;
        cyc = 0;
        while (got < 50 && cyc < 5000) begin
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected_result", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("rand%0d_sum", got), 32'(bus.sum), 32'(e[W-1:0]));
              check($sformatf("rand%0d_cout", got), 32'(bus.cout), 32'(e[W]));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
              check($sformatf("rand%0d_ovf", got), 32'(bus.ovf), 32'(e[W+1]));
`endif
            end
            got++;
          end
          tick();
          cyc++;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        check("rand_results_received", 32'(got), 32'd50);
      end
    join
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("rand_no_duplicates", 32'(seen), 32'd0);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
